// File: rtl/scanmon_pkg.sv
// Shared constants and helpers for the PS/2 scancode monitor.
package scanmon_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    if (r == 0) r = 1;
    return r;
  endfunction

  // Active-low {g,f,e,d,c,b,a}; b and d are lowercase glyphs.
  function automatic logic [6:0] hex2seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/scancode_monitor_seg7_scanner.sv
// Multiplexed 7-seg scanner: prescaler, digit counter, and an/seg registered together.
module seg7_scanner
  import scanmon_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 50000,
  localparam int DW = clog2(NUM_DIGITS),
  localparam int PW = clog2(PRESCALE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            nibble,
  input  logic                  blank,
  output logic [DW-1:0]         digit,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg
);

  logic [PW-1:0]         prescale_q, prescale_d;
  logic [DW-1:0]         digit_q, digit_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;

  always_comb begin
    prescale_d = prescale_q + PW'(1);
    digit_d    = digit_q;
    if (prescale_q == PW'(PRESCALE - 1)) begin
      prescale_d = '0;
      digit_d    = (digit_q == DW'(NUM_DIGITS - 1)) ? '0 : digit_q + DW'(1);
    end
    // Anode and pattern come from the same digit index, so they always switch together.
    an_d  = ~(NUM_DIGITS'(1) << digit_q);
    seg_d = blank ? SEG_BLANK : hex2seg(nibble);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescale_q <= '0;
      digit_q    <= '0;
      an_q       <= '1;
      seg_q      <= SEG_BLANK;
    end else begin
      prescale_q <= prescale_d;
      digit_q    <= digit_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
    end
  end

  assign digit = digit_q;
  assign an    = an_q;
  assign seg   = seg_q;

endmodule

// File: rtl/scancode_monitor.sv
// PS/2 scancode history viewer with scrollable hex window on a multiplexed 7-seg display.
// Optional capture freeze input enabled by defining SCANMON_HOLD_EN.
module scancode_monitor
  import scanmon_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DEPTH      = 8,
  parameter int PRESCALE   = 50000,
  localparam int CW    = clog2(DEPTH + 1),
  localparam int DW    = clog2(NUM_DIGITS),
  localparam int BYTES = NUM_DIGITS / 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  kb_valid,
  input  logic [7:0]            scancode,
  input  logic                  released,
  input  logic                  extended,
  input  logic                  scroll_up,
  input  logic                  scroll_dn,
`ifdef SCANMON_HOLD_EN
  input  logic                  hold,
`endif
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  ledreleased,
  output logic                  ledextended,
  output logic [CW-1:0]         count
);

  logic [7:0]    hist_q [DEPTH];
  logic [7:0]    hist_d [DEPTH];
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] offset_q, offset_d;
  logic          rel_q, rel_d;
  logic          ext_q, ext_d;

  logic          capture;
  logic [CW-1:0] maxoff;
  logic [DW-1:0] digit;
  logic [CW-1:0] byte_sel;
  logic [7:0]    sel_byte;
  logic [3:0]    nibble;
  logic          blank;

`ifdef SCANMON_HOLD_EN
  assign capture = kb_valid & ~hold;
`else
  assign capture = kb_valid;
`endif

  assign maxoff = (count_q > CW'(BYTES)) ? count_q - CW'(BYTES) : '0;

  always_comb begin
    hist_d   = hist_q;
    count_d  = count_q;
    offset_d = offset_q;
    rel_d    = rel_q;
    ext_d    = ext_q;
    if (capture) begin
      hist_d[0] = scancode;
      for (int i = 1; i < DEPTH; i++) hist_d[i] = hist_q[i-1];
      if (count_q != CW'(DEPTH)) count_d = count_q + CW'(1);
      rel_d    = released;
      ext_d    = extended;
      offset_d = '0;
    end else if (scroll_up && !scroll_dn) begin
      if (offset_q < maxoff) offset_d = offset_q + CW'(1);
    end else if (scroll_dn && !scroll_up) begin
      if (offset_q != '0) offset_d = offset_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) hist_q[i] <= '0;
      count_q  <= '0;
      offset_q <= '0;
      rel_q    <= 1'b0;
      ext_q    <= 1'b0;
    end else begin
      hist_q   <= hist_d;
      count_q  <= count_d;
      offset_q <= offset_d;
      rel_q    <= rel_d;
      ext_q    <= ext_d;
    end
  end

  // Two digits per byte: digit/2 picks the byte in the window, digit[0] picks the nibble.
  always_comb begin
    byte_sel = offset_q + CW'(digit >> 1);
    sel_byte = '0;
    for (int i = 0; i < DEPTH; i++)
      if (byte_sel == CW'(i)) sel_byte = hist_q[i];
    nibble = digit[0] ? sel_byte[7:4] : sel_byte[3:0];
    blank  = (byte_sel >= count_q);
  end

  seg7_scanner #(
    .NUM_DIGITS(NUM_DIGITS),
    .PRESCALE  (PRESCALE)
  ) u_scan (
    .clk   (clk),
    .rst   (rst),
    .nibble(nibble),
    .blank (blank),
    .digit (digit),
    .an    (an),
    .seg   (seg)
  );

  assign ledreleased = rel_q;
  assign ledextended = ext_q;
  assign count       = count_q;

endmodule
